// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the command parser
// and the downstream command dispatcher.
`timescale 1ns/1ps
interface uart_cmd_parser_if #(
  parameter int PAYLOAD_W = 52
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [PAYLOAD_W-1:0] cmd_payload;
  logic                 err;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_op, cmd_payload, err, busy
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_op, cmd_payload, err, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII host command decoder: "*<op><hex digits>" frames become one binary
// command held under a valid/ready handshake.
`timescale 1ns/1ps
module uart_cmd_parser #(
  parameter int PAYLOAD_W = 52,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_parser_if.slave bus
);

  localparam logic [7:0] STAR = 8'h2A;

  typedef enum logic [1:0] {IDLE, OPCODE, DIGITS, ISSUE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] acc_q, acc_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic                 err_q, err_d;

  logic [4:0]           hex_w;
  logic [3:0]           opd_w;
  logic [PAYLOAD_W-1:0] shifted_w;

  // Returns {is_hex, nibble}; letters a-f/A-F share the low nibble 1..6.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
      return {1'b1, 4'(c[3:0] + 4'd9)};
    return 5'b0;
  endfunction

  // Returns {known, op}; lowercase letters only.
  function automatic logic [3:0] op_decode(input logic [7:0] c);
    case (c)
      8'h70:   return 4'b1_000;
      8'h6D:   return 4'b1_001;
      8'h67:   return 4'b1_010;
      8'h63:   return 4'b1_011;
      8'h65:   return 4'b1_100;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] digit_count(input logic [2:0] op);
    case (op)
      3'd0:    return CNT_W'(13);
      3'd1:    return CNT_W'(7);
      3'd2:    return CNT_W'(8);
      default: return CNT_W'(3);
    endcase
  endfunction

  assign hex_w     = hex_nib(bus.rx_data);
  assign opd_w     = op_decode(bus.rx_data);
  assign shifted_w = {acc_q[PAYLOAD_W-5:0], hex_w[3:0]};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pay_d   = pay_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == STAR) state_d = OPCODE;
      end
      OPCODE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == STAR) begin
            state_d = OPCODE;
          end else if (opd_w[3]) begin
            op_d    = opd_w[2:0];
            cnt_d   = digit_count(opd_w[2:0]);
            acc_d   = '0;
            state_d = DIGITS;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DIGITS: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == STAR) begin
            err_d   = 1'b1;
            state_d = OPCODE;
          end else if (hex_w[4]) begin
            acc_d = shifted_w;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              pay_d   = shifted_w;
              state_d = ISSUE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ISSUE: begin
        // Bytes arriving while a command is pending are dropped, even a '*'
        // that lands on the handshake edge.
        if (bus.rx_valid) err_d = 1'b1;
        if (bus.cmd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      pay_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pay_q   <= pay_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_valid   = (state_q == ISSUE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.cmd_op      = op_q;
  assign bus.cmd_payload = pay_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frame stimulus for uart_cmd_parser with a
// frame-level expectation model and a handshake monitor.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int PW = 52;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.PAYLOAD_W(PW)) bus ();
  uart_cmd_parser #(.PAYLOAD_W(PW), .CNT_W(4)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  int err_cnt, vld_cycles, stab_bad;
  logic [2:0]    obs_op[$];
  logic [PW-1:0] obs_pl[$];
  logic [2:0]    exp_op[$];
  logic [PW-1:0] exp_pl[$];
  int rdy_mode = 1;

  logic          pv = 1'b0, phs = 1'b0;
  logic [2:0]    pop = '0;
  logic [PW-1:0] ppl = '0;

  // 0: hold ready low, 1: hold high, 2: random per cycle
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.cmd_ready = 1'b0;
      1:       bus.cmd_ready = 1'b1;
      default: bus.cmd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err === 1'b1) err_cnt++;
      if (bus.cmd_valid === 1'b1) vld_cycles++;
      if (bus.cmd_valid === 1'b1 && pv && !phs &&
          (bus.cmd_op !== pop || bus.cmd_payload !== ppl)) stab_bad++;
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        obs_op.push_back(bus.cmd_op);
        obs_pl.push_back(bus.cmd_payload);
      end
      pv  = (bus.cmd_valid === 1'b1);
      pop = bus.cmd_op;
      ppl = bus.cmd_payload;
      phs = (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1);
    end else begin
      pv  = 1'b0;
      phs = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] c);
    bus.rx_data  = c;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("idle_reached", 64'(bus.busy), 64'(0));
  endtask

  task automatic clear();
    err_cnt = 0;
    vld_cycles = 0;
    stab_bad = 0;
    obs_op.delete();
    obs_pl.delete();
  endtask

  task automatic chk_cmd(input string tag, input int idx, input logic [2:0] op, input logic [PW-1:0] pl);
    if (obs_op.size() > idx) begin
      chk({tag, "_op"}, 64'(obs_op[idx]), 64'(op));
      chk({tag, "_payload"}, 64'(obs_pl[idx]), 64'(pl));
    end else begin
      chk({tag, "_missing"}, 64'(obs_op.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    string ops;
    int    lens[5];
    ops = "pmgce";
    lens = '{13, 7, 8, 3, 3};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    clear();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.cmd_valid), 64'(0));
    chk("rst_op", 64'(bus.cmd_op), 64'(0));
    chk("rst_payload", 64'(bus.cmd_payload), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    rst_n = 1'b1;
    tick();

    // particle write, ready held high
    clear();
    send_str("*p4000200002000", 0);
    wait_idle();
    chk("p_count", 64'(obs_op.size()), 64'(1));
    chk_cmd("p", 0, 3'd0, 52'h4000200002000);
    chk("p_err", 64'(err_cnt), 64'(0));
    chk("p_valid_cycles", 64'(vld_cycles), 64'(1));

    // two frames in sequence
    clear();
    send_str("*m000ffff", 0);
    wait_idle();
    send_str("*g00000004", 0);
    wait_idle();
    chk("mg_count", 64'(obs_op.size()), 64'(2));
    chk_cmd("m", 0, 3'd1, 52'hFFFF);
    chk_cmd("g", 1, 3'd2, 52'h4);
    chk("mg_err", 64'(err_cnt), 64'(0));

    // '*' landing on the handshake edge is dropped, so the rest is noise
    clear();
    send_str("*c001", 0);
    send_str("*e123", 0);
    wait_idle();
    chk("ovr_count", 64'(obs_op.size()), 64'(1));
    chk_cmd("ovr", 0, 3'd3, 52'h1);
    chk("ovr_err", 64'(err_cnt), 64'(1));

    // held command with overrun byte
    clear();
    rdy_mode = 0;
    tick();
    send_str("*c202", 0);
    repeat (2) tick();
    chk("hold_valid_a", 64'(bus.cmd_valid), 64'(1));
    chk("hold_op_a", 64'(bus.cmd_op), 64'(3));
    chk("hold_payload_a", 64'(bus.cmd_payload), 64'(52'h202));
    send_byte("x");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_valid", 64'(bus.cmd_valid), 64'(1));
      chk("hold_payload", 64'(bus.cmd_payload), 64'(52'h202));
    end
    chk("hold_err", 64'(err_cnt), 64'(1));
    chk("hold_no_xfer", 64'(obs_op.size()), 64'(0));
    rdy_mode = 1;
    tick();
    chk("hold_xfer", 64'(obs_op.size()), 64'(1));
    chk("hold_busy_fall", 64'(bus.busy), 64'(0));
    chk("hold_valid_fall", 64'(bus.cmd_valid), 64'(0));
    chk("hold_stable", 64'(stab_bad), 64'(0));
    wait_idle();

    // protocol errors
    clear();
    send_str("*q12", 0);
    wait_idle();
    chk("badop_err", 64'(err_cnt), 64'(1));
    chk("badop_count", 64'(obs_op.size()), 64'(0));

    clear();
    send_str("*e2G2", 0);
    wait_idle();
    chk("badhex_err", 64'(err_cnt), 64'(1));
    chk("badhex_count", 64'(obs_op.size()), 64'(0));

    clear();
    send_str("*p12*e1AB", 0);
    wait_idle();
    chk("restart_err", 64'(err_cnt), 64'(1));
    chk("restart_count", 64'(obs_op.size()), 64'(1));
    chk_cmd("restart", 0, 3'd4, 52'h1AB);

    clear();
    send_str("hello*e202", 0);
    wait_idle();
    chk("noise_err", 64'(err_cnt), 64'(0));
    chk_cmd("noise", 0, 3'd4, 52'h202);

    // asynchronous reset mid-frame
    clear();
    send_str("*g0000", 0);
    chk("mid_busy", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_payload", 64'(bus.cmd_payload), 64'(0));
    chk("arst_op", 64'(bus.cmd_op), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_valid", 64'(bus.cmd_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    clear();
    send_str("*g00000010", 0);
    wait_idle();
    chk("post_rst_count", 64'(obs_op.size()), 64'(1));
    chk_cmd("post_rst", 0, 3'd2, 52'h10);
    chk("post_rst_err", 64'(err_cnt), 64'(0));

    // randomized frames, noise and random ready
    clear();
    exp_op.delete();
    exp_pl.delete();
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int k;
      int nn;
      logic [PW-1:0] v;
      nn = $urandom_range(0, 2);
      for (int j = 0; j < nn; j++) begin
        int b;
        b = $urandom_range(33, 126);
        if (b == 42) b = 43;
        send_byte(8'(b));
      end
      k = $urandom_range(0, 4);
      v = '0;
      send_byte("*");
      send_byte(ops[k]);
      for (int j = 0; j < lens[k]; j++) begin
        int d;
        int c;
        d = $urandom_range(0, 15);
        if (d < 10) c = 48 + d;
        else c = ($urandom_range(0, 1) == 1 ? 87 : 55) + d;
        v = v * 16 + PW'(d);
        send_byte(8'(c));
        repeat ($urandom_range(0, 1)) tick();
      end
      exp_op.push_back(3'(k));
      exp_pl.push_back(v);
      wait_idle();
    end
    rdy_mode = 1;
    tick();
    chk("rand_count", 64'(obs_op.size()), 64'(exp_op.size()));
    for (int i = 0; i < exp_op.size(); i++) chk_cmd("rand", i, exp_op[i], exp_pl[i]);
    chk("rand_err", 64'(err_cnt), 64'(0));
    chk("rand_stable", 64'(stab_bad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
